// File: rtl/frame_animator.sv
// Frame-synchronous bus-write sequencer: each vsync rising edge sweeps the
// channel table once and issues one bus write for every channel that is due.
module frame_animator #(
    parameter int NUM_CH   = 4,
    parameter int ADDR_W   = 16,
    parameter int DATA_W   = 8,
    parameter int PERIOD_W = 4,
    localparam int CH_W    = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              vsync,
    input  logic              cfg_we,
    input  logic [CH_W-1:0]   cfg_ch,
    input  logic [1:0]        cfg_field,
    input  logic [ADDR_W-1:0] cfg_data,
    input  logic              overrun_clr,
    output logic [ADDR_W-1:0] addr,
    output logic [DATA_W-1:0] data,
    output logic              rw,
    output logic              busy,
    output logic              done,
    output logic              overrun,
    output logic [1:0]        state_dbg
);

    // Bus handshake: a write is the single cycle with rw = 1; addr/data are
    // valid in that cycle and hold their last values otherwise. No back-pressure.

    typedef enum logic [1:0] {S_IDLE = 2'd0, S_SWEEP = 2'd1, S_DONE = 2'd2} state_t;

    localparam logic [CH_W:0]   NUM_CH_L = (CH_W + 1)'(NUM_CH);
    localparam logic [CH_W-1:0] LAST_CH  = CH_W'(NUM_CH - 1);

    state_t            state;
    logic [CH_W-1:0]   idx;
    logic              vsync_q;
    logic              start;

    logic [ADDR_W-1:0]   ch_addr   [NUM_CH];
    logic [DATA_W-1:0]   ch_val    [NUM_CH];
    logic [DATA_W-1:0]   ch_step   [NUM_CH];
    logic                ch_en     [NUM_CH];
    logic                ch_mode   [NUM_CH];
    logic [PERIOD_W-1:0] ch_period [NUM_CH];
    logic [PERIOD_W-1:0] ch_cnt    [NUM_CH];

    logic              cfg_ok;
    logic              collide;
    logic [DATA_W-1:0] cur_val;
    logic [DATA_W-1:0] cur_step;
    logic [DATA_W+1:0] nv;
    logic              step_neg;
    logic              sat_lo;
    logic              sat_hi;
    logic              sat;
    logic [DATA_W-1:0] new_val;

    assign start     = vsync & ~vsync_q;
    assign state_dbg = state;
    assign cfg_ok    = cfg_we && ({1'b0, cfg_ch} < NUM_CH_L);
    assign collide   = cfg_ok && (cfg_ch == idx);

    // Two guard bits hold the sign-extended sum so both bound crossings show up.
    // Saturation triggers on reaching or passing the bound in the step's direction.
    always_comb begin
        cur_val  = ch_val[idx];
        cur_step = ch_step[idx];
        step_neg = cur_step[DATA_W-1];
        nv       = {2'b00, cur_val} + {{2{step_neg}}, cur_step};
        sat_lo   = step_neg && (nv[DATA_W+1] || (nv == '0));
        sat_hi   = !step_neg && (cur_step != '0) && !nv[DATA_W+1] &&
                   (nv[DATA_W] || (nv[DATA_W-1:0] == '1));
        sat      = ch_mode[idx] && (sat_lo || sat_hi);
        new_val  = nv[DATA_W-1:0];
        if (ch_mode[idx] && sat_lo) begin
            new_val = '0;
        end else if (ch_mode[idx] && sat_hi) begin
            new_val = '1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int k = 0; k < NUM_CH; k++) begin
                ch_addr[k]   <= '0;
                ch_val[k]    <= '0;
                ch_step[k]   <= '0;
                ch_en[k]     <= 1'b0;
                ch_mode[k]   <= 1'b0;
                ch_period[k] <= '0;
                ch_cnt[k]    <= '0;
            end
            state   <= S_IDLE;
            idx     <= '0;
            vsync_q <= 1'b0;
            addr    <= '0;
            data    <= '0;
            rw      <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
            overrun <= 1'b0;
        end else begin
            vsync_q <= vsync;
            rw      <= 1'b0;
            done    <= 1'b0;

            if (start && busy) begin
                overrun <= 1'b1;
            end else if (overrun_clr) begin
                overrun <= 1'b0;
            end

            case (state)
                S_IDLE: begin
                    if (start) begin
                        state <= S_SWEEP;
                        idx   <= '0;
                        busy  <= 1'b1;
                    end
                end
                S_SWEEP: begin
                    // A same-cycle config write to this channel takes precedence.
                    if (!collide && ch_en[idx]) begin
                        if (ch_cnt[idx] != '0) begin
                            ch_cnt[idx] <= ch_cnt[idx] - 1'b1;
                        end else begin
                            ch_cnt[idx] <= ch_period[idx];
                            ch_val[idx] <= new_val;
                            if (sat) begin
                                ch_en[idx] <= 1'b0;
                            end
                            addr <= ch_addr[idx];
                            data <= new_val;
                            rw   <= 1'b1;
                        end
                    end
                    if (idx == LAST_CH) begin
                        state <= S_DONE;
                        done  <= 1'b1;
                    end else begin
                        idx <= idx + 1'b1;
                    end
                end
                S_DONE: begin
                    state <= S_IDLE;
                    busy  <= 1'b0;
                end
                default: begin
                    state <= S_IDLE;
                    busy  <= 1'b0;
                end
            endcase

            if (cfg_ok) begin
                case (cfg_field)
                    2'd0: ch_addr[cfg_ch] <= cfg_data;
                    2'd1: ch_val[cfg_ch]  <= cfg_data[DATA_W-1:0];
                    2'd2: ch_step[cfg_ch] <= cfg_data[DATA_W-1:0];
                    default: begin
                        ch_period[cfg_ch] <= cfg_data[PERIOD_W-1:0];
                        ch_en[cfg_ch]     <= cfg_data[PERIOD_W];
                        ch_mode[cfg_ch]   <= cfg_data[PERIOD_W+1];
                        ch_cnt[cfg_ch]    <= '0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_frame_animator.sv
// Bench for frame_animator: scoreboarded bus writes plus per-frame timing masks.
module tb_frame_animator;

    localparam int NUM_CH   = 4;
    localparam int ADDR_W   = 16;
    localparam int DATA_W   = 8;
    localparam int PERIOD_W = 4;
    localparam int CH_W     = 2;
    localparam int W        = ADDR_W + DATA_W;

    logic              clk = 1'b0;
    logic              reset = 1'b0;
    logic              vsync = 1'b0;
    logic              cfg_we = 1'b0;
    logic [CH_W-1:0]   cfg_ch = '0;
    logic [1:0]        cfg_field = '0;
    logic [ADDR_W-1:0] cfg_data = '0;
    logic              overrun_clr = 1'b0;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
    logic              rw;
    logic              busy;
    logic              done;
    logic              overrun;
    logic [1:0]        state_dbg;

    int checks = 0;
    int errors = 0;
    logic [W-1:0] exp_q[$];
    logic [W-1:0] exp_w;

    logic [ADDR_W-1:0] m_addr [NUM_CH];
    logic [DATA_W-1:0] m_val  [NUM_CH];
    logic [DATA_W-1:0] m_step [NUM_CH];
    logic              m_en   [NUM_CH];

    logic [15:0] rw_m, busy_m, done_m;

    frame_animator #(
        .NUM_CH(NUM_CH), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .PERIOD_W(PERIOD_W)
    ) dut (
        .clk(clk), .reset(reset), .vsync(vsync), .cfg_we(cfg_we), .cfg_ch(cfg_ch),
        .cfg_field(cfg_field), .cfg_data(cfg_data), .overrun_clr(overrun_clr),
        .addr(addr), .data(data), .rw(rw), .busy(busy), .done(done),
        .overrun(overrun), .state_dbg(state_dbg)
    );

    // ---------------- clock / watchdog ----------------
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog got timeout expected finish");
        $fatal(1, "watchdog");
    end

    // ---------------- scoreboard ----------------
    always @(negedge clk) begin
        if (reset && rw) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_write got addr=%h data=%h expected none", addr, data);
            end else begin
                exp_w = exp_q.pop_front();
                if ({addr, data} !== exp_w) begin
                    errors++;
                    $display("FAIL bus_write got addr=%h data=%h expected addr=%h data=%h",
                             addr, data, exp_w[W-1:DATA_W], exp_w[DATA_W-1:0]);
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic cfg_write(input logic [CH_W-1:0] ch, input logic [1:0] f, input logic [15:0] d);
        @(posedge clk); #1;
        cfg_we = 1'b1; cfg_ch = ch; cfg_field = f; cfg_data = d;
        @(posedge clk); #1;
        cfg_we = 1'b0;
    endtask

    task automatic program_ch(input int ch, input logic [15:0] a, input logic [7:0] v,
                              input logic [7:0] s, input logic [15:0] ctrl);
        cfg_write(CH_W'(ch), 2'd0, a);
        cfg_write(CH_W'(ch), 2'd1, {8'h00, v});
        cfg_write(CH_W'(ch), 2'd2, {8'h00, s});
        cfg_write(CH_W'(ch), 2'd3, ctrl);
        m_addr[ch] = a; m_val[ch] = v; m_step[ch] = s; m_en[ch] = ctrl[PERIOD_W];
    endtask

    // Wrap-mode, period-0 reference: every enabled channel except skip steps once.
    task automatic push_due(input int skip);
        for (int k = 0; k < NUM_CH; k++) begin
            if (m_en[k] && k != skip) begin
                m_val[k] = m_val[k] + m_step[k];
                exp_q.push_back({m_addr[k], m_val[k]});
            end
        end
    endtask

    // vsync rises in cycle T (k = 0); bit k of each mask is the output in cycle T+k.
    task automatic run_frame(input int vs2_k, input int cfg_k, input logic [CH_W-1:0] c,
                             input logic [1:0] f, input logic [15:0] d, input int rst_k,
                             input int clr_k,
                             output logic [15:0] rwm, output logic [15:0] bm, output logic [15:0] dm);
        rwm = '0; bm = '0; dm = '0;
        @(posedge clk); #1;
        vsync = 1'b1;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            rwm[k] = rw; bm[k] = busy; dm[k] = done;
            @(posedge clk); #1;
            vsync       = (k + 1 == vs2_k);
            overrun_clr = (k + 1 == clr_k);
            cfg_we      = (k + 1 == cfg_k);
            if (k + 1 == cfg_k) begin
                cfg_ch = c; cfg_field = f; cfg_data = d;
            end
            reset = !(rst_k >= 0 && k + 1 >= rst_k && k + 1 < rst_k + 3);
        end
        vsync = 1'b0; overrun_clr = 1'b0; cfg_we = 1'b0; reset = 1'b1;
    endtask

    task automatic frame(output logic [15:0] rwm, output logic [15:0] bm, output logic [15:0] dm);
        run_frame(-1, -1, '0, 2'd0, 16'h0, -1, -1, rwm, bm, dm);
    endtask

    task automatic check_drained(input string name);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL %s pending got %0d expected 0", name, exp_q.size());
        end
        exp_q.delete();
    endtask

    task automatic check_mask(input string name, input logic [15:0] got, input logic [15:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s got %h expected %h", name, got, want);
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            vsync = (i == 1); cfg_we = 1'b1; cfg_field = 2'd3; cfg_data = 16'h0010;
            @(negedge clk);
            checks++;
            if ({addr, data, rw, busy, done, overrun, state_dbg} !== '0) begin
                errors++;
                $display("FAIL reset_outputs got addr=%h data=%h rw=%b busy=%b done=%b ovr=%b st=%0d expected 0",
                         addr, data, rw, busy, done, overrun, state_dbg);
            end
        end
        @(posedge clk); #1;
        vsync = 1'b0; cfg_we = 1'b0; reset = 1'b1;
        repeat (2) @(posedge clk);
        frame(rw_m, busy_m, done_m);
        check_mask("reset_rw", rw_m, 16'h0000);
        check_mask("reset_busy", busy_m, 16'h003E);
        check_mask("reset_done", done_m, 16'h0020);
        check_mask("reset_overrun", {15'b0, overrun}, 16'h0000);
    endtask

    task automatic test_wrap();
        logic [7:0] want [3];
        want[0] = 8'hFF; want[1] = 8'h00; want[2] = 8'h01;
        program_ch(0, 16'hFC05, 8'hFE, 8'h01, 16'h0010);
        for (int i = 0; i < 3; i++) begin
            exp_q.push_back({16'hFC05, want[i]});
            frame(rw_m, busy_m, done_m);
            check_mask("wrap_rw", rw_m, 16'h0004);
        end
        check_drained("wrap");
        cfg_write(2'd0, 2'd3, 16'h0000);
        m_en[0] = 1'b0;
    endtask

    task automatic test_saturate();
        logic [15:0] want [6];
        want[0] = 16'h0008; want[1] = 16'h0000; want[2] = 16'h0008;
        want[3] = 16'h0000; want[4] = 16'h0000; want[5] = 16'h0000;
        program_ch(1, 16'hFBF8, 8'h04, 8'hFE, 16'h0031);
        for (int i = 0; i < 6; i++) begin
            if (i == 0) exp_q.push_back({16'hFBF8, 8'h02});
            if (i == 2) exp_q.push_back({16'hFBF8, 8'h00});
            frame(rw_m, busy_m, done_m);
            check_mask("sat_rw", rw_m, want[i]);
        end
        check_drained("saturate");
        cfg_write(2'd1, 2'd3, 16'h0000);
        m_en[1] = 1'b0;
    endtask

    task automatic test_back_to_back();
        for (int k = 0; k < NUM_CH; k++)
            program_ch(k, 16'h1000 + 16'(k), 8'(k * 16), 8'h01, 16'h0010);
        push_due(-1);
        frame(rw_m, busy_m, done_m);
        check_mask("b2b_rw", rw_m, 16'h003C);
        check_mask("b2b_done", done_m, 16'h0020);
        for (int k = 0; k < NUM_CH; k++)
            program_ch(k, 16'($urandom_range(0, 65535)), 8'($urandom_range(0, 255)),
                       8'($urandom_range(0, 255)), 16'h0010);
        for (int i = 0; i < 2; i++) begin
            push_due(-1);
            frame(rw_m, busy_m, done_m);
            check_mask("rand_rw", rw_m, 16'h003C);
        end
        check_drained("back_to_back");
    endtask

    task automatic test_overrun();
        push_due(-1);
        run_frame(2, -1, '0, 2'd0, 16'h0, -1, -1, rw_m, busy_m, done_m);
        check_mask("ovr_rw", rw_m, 16'h003C);
        check_mask("ovr_busy", busy_m, 16'h003E);
        check_mask("ovr_done", done_m, 16'h0020);
        check_mask("ovr_set", {15'b0, overrun}, 16'h0001);
        repeat (3) @(posedge clk);
        check_mask("ovr_sticky", {15'b0, overrun}, 16'h0001);
        @(posedge clk); #1 overrun_clr = 1'b1;
        @(posedge clk); #1 overrun_clr = 1'b0;
        @(negedge clk);
        check_mask("ovr_clr", {15'b0, overrun}, 16'h0000);
        // Clear and a new set condition in the same cycle: set wins.
        push_due(-1);
        run_frame(3, -1, '0, 2'd0, 16'h0, -1, 3, rw_m, busy_m, done_m);
        check_mask("ovr_set_wins", {15'b0, overrun}, 16'h0001);
        check_mask("ovr2_rw", rw_m, 16'h003C);
        cfg_write(2'd0, 2'd3, 16'h0010);
        @(posedge clk); #1 overrun_clr = 1'b1;
        @(posedge clk); #1 overrun_clr = 1'b0;
        check_drained("overrun");
    endtask

    task automatic test_collision();
        program_ch(2, 16'h3000, 8'h10, 8'h03, 16'h0010);
        push_due(2);
        m_val[2] = 8'h40;
        run_frame(-1, 3, 2'd2, 2'd1, 16'h0040, -1, -1, rw_m, busy_m, done_m);
        check_mask("coll_rw", rw_m, 16'h002C);
        check_drained("collision_frame");
        push_due(-1);
        frame(rw_m, busy_m, done_m);
        check_mask("coll_next_rw", rw_m, 16'h003C);
        check_mask("coll_new_val", {8'h00, m_val[2]}, 16'h0043);
        check_drained("collision_next");
    endtask

    task automatic test_reset_abort();
        run_frame(-1, -1, '0, 2'd0, 16'h0, 2, -1, rw_m, busy_m, done_m);
        check_mask("abort_rw", rw_m, 16'h0000);
        check_mask("abort_busy", busy_m, 16'h0002);
        check_mask("abort_done", done_m, 16'h0000);
        check_mask("abort_state", {14'b0, state_dbg}, 16'h0000);
        for (int k = 0; k < NUM_CH; k++) m_en[k] = 1'b0;
        frame(rw_m, busy_m, done_m);
        check_mask("post_abort_rw", rw_m, 16'h0000);
        check_mask("post_abort_busy", busy_m, 16'h003E);
        check_drained("reset_abort");
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        for (int k = 0; k < NUM_CH; k++) begin
            m_addr[k] = '0; m_val[k] = '0; m_step[k] = '0; m_en[k] = 1'b0;
        end
        test_reset();
        test_wrap();
        test_saturate();
        test_back_to_back();
        test_overrun();
        test_collision();
        test_reset_abort();
        repeat (4) @(posedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
